multicycle_control: RTL

Control finite-state machine (FSM) for the multicycle RV32I-subset core. It decodes the instruction register output and sequences the fetch, decode, execute, memory and writeback phases. Each cycle it drives every datapath control input: PC write enable, memory address select, memory read/write, instruction register write, register file write, writeback select, ALU operand selects, PC source and the 4-bit ALU control. It sits directly upstream of the datapath and also consumes the ALU `zero` flag.

---
 rtl/multicycle_control.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I-subset core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath control input. Define BRANCH_BNE_EN to also support bne (funct3 001).
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        pc_write,
    output logic        ior_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_source,
    output logic [3:0]  alu_control,
    output logic        retire,
    output logic        illegal
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        BR_NT     = 4'd10,
        TRAP      = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_inst_bits;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign funct7           = inst[31:25];
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

    logic             r_ok, i_ok, br_ok, br_cond;
    logic [ALU_W-1:0] r_alu, i_alu;

    // Instruction field decode for the execute and branch states.
    always_comb begin : decode
        r_ok    = 1'b1;
        r_alu   = ALU_AND;
        i_ok    = 1'b1;
        i_alu   = ALU_AND;
        br_ok   = 1'b0;
        br_cond = 1'b0;

        case ({funct7, funct3})
            {7'b0000000, 3'b000}: r_alu = ALU_ADD;
            {7'b0100000, 3'b000}: r_alu = ALU_SUB;
            {7'b0000000, 3'b111}: r_alu = ALU_AND;
            {7'b0000000, 3'b110}: r_alu = ALU_OR;
            default:              r_ok  = 1'b0;
        endcase

        case (funct3)
            3'b000:  i_alu = ALU_ADD;
            3'b111:  i_alu = ALU_AND;
            3'b110:  i_alu = ALU_OR;
            default: i_ok  = 1'b0;
        endcase

        case (funct3)
            3'b000: begin
                br_ok   = 1'b1;
                br_cond = zero;
            end
`ifdef BRANCH_BNE_EN
            3'b001: begin
                br_ok   = 1'b1;
                br_cond = ~zero;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        state_q   <= state_d;
        illegal_q <= illegal_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_BRANCH:    state_d = BRANCH;
                    default:      state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                if (opcode == OP_SW)      state_d = MEM_WRITE;
                else if (opcode == OP_LW) state_d = MEM_READ;
                else                      state_d = TRAP;
            end
            MEM_READ:  state_d = MEM_WB;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: state_d = FETCH;
            EXEC_R:    state_d = r_ok ? ALU_WB : TRAP;
            EXEC_I:    state_d = i_ok ? ALU_WB : TRAP;
            ALU_WB:    state_d = FETCH;
            BRANCH: begin
                if (!br_ok)       state_d = TRAP;
                else if (br_cond) state_d = FETCH;
                else              state_d = BR_NT;
            end
            BR_NT:   state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        if (reset) state_d = FETCH;
        // Sticky until reset; rises together with entry into TRAP.
        illegal_d = reset ? 1'b0 : (illegal_q | (state_d == TRAP));
    end

    logic pc4;

    // Moore outputs from the state register, except the Mealy taken-branch PC write.
    always_comb begin : outputs
        pc_write    = 1'b0;
        ior_d       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 1'b0;
        alu_control = ALU_AND;
        retire      = 1'b0;
        illegal     = 1'b0;
        pc4         = 1'b0;

        if (!reset) begin
            illegal = illegal_q;
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                end
                DECODE: begin
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                MEM_ADDR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    ior_d    = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    pc4        = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    ior_d     = 1'b1;
                    pc4       = 1'b1;
                end
                EXEC_R: begin
                    alu_src_a   = 1'b1;
                    alu_control = r_alu;
                end
                EXEC_I: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = i_alu;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    pc4       = 1'b1;
                end
                BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_source   = 1'b1;
                    pc_write    = br_ok & br_cond;
                    retire      = br_ok & br_cond;
                end
                BR_NT:   pc4 = 1'b1;
                default: begin
                end
            endcase

            if (pc4) begin
                alu_src_a   = 1'b0;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                pc_source   = 1'b0;
                pc_write    = 1'b1;
                retire      = 1'b1;
            end
        end
    end

endmodule
